// File: rtl/conv_window_gen_pkg.sv
// Shared 3x3 window geometry and packing, common to the window generator and Conv2D.
package conv_pkg;

    localparam int unsigned CH_W    = 8;
    localparam int unsigned NCH     = 3;
    localparam int unsigned PIX_W   = NCH * CH_W;
    localparam int unsigned WIN_DIM = 3;
    localparam int unsigned WIN_W   = WIN_DIM * WIN_DIM * PIX_W;
    localparam int unsigned IDX_W   = 6;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [WIN_W-1:0] win_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Bit offset of channel k of element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int unsigned win_off(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned k);
        return ((r * WIN_DIM + c) * NCH + k) * CH_W;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_gen_if;

    conv_pkg::pix_t pix_in;
    logic           pix_valid;
    logic           pix_ready;
    conv_pkg::win_t win_data;
    logic           win_valid;
    logic           win_ready;
    conv_pkg::idx_t win_row;
    conv_pkg::idx_t win_col;
    logic           frame_done;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_data, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_data, win_valid, win_row, win_col, frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixels: simple dual-port RAM, synchronous read, old data on collision.
module line_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 RGB window generator: two row buffers feed a 3-column shift window.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave bus
);

    localparam int unsigned LB_AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam idx_t        IDX_TWO = idx_t'(2);

    idx_t x_q, x_d;
    idx_t y_q, y_d;
    pix_t sw_q [WIN_DIM][WIN_DIM];
    pix_t sw_d [WIN_DIM][WIN_DIM];
    win_t win_data_q, win_data_d;
    logic win_valid_q, win_valid_d;
    idx_t win_row_q, win_row_d;
    idx_t win_col_q, win_col_d;
    logic frame_done_q, frame_done_d;

    logic             pix_ready;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             emit;
    pix_t             lb0_rdata;
    pix_t             lb1_rdata;
    logic [LB_AW-1:0] lb_waddr;
    logic [LB_AW-1:0] lb_raddr;

    assign pix_ready = !win_valid_q || bus.win_ready;
    assign accept    = bus.pix_valid && pix_ready;

    always_comb begin
        last_col = (x_q == idx_t'(IMG_W - 1));
        last_row = (y_q == idx_t'(IMG_H - 1));
        emit     = accept && (y_q >= IDX_TWO) && (x_q >= IDX_TWO);

        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (last_col) begin
                x_d = '0;
                y_d = last_row ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // The RAMs are read at the next column continuously, so column x of rows y-2 and y-1
    // is already on rdata when pixel (y,x) is accepted; a stall keeps the address steady.
    assign lb_raddr = x_d[LB_AW-1:0];
    assign lb_waddr = x_q[LB_AW-1:0];

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (LB_AW)
    ) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (lb_waddr),
        .wdata_i (lb1_rdata),
        .raddr_i (lb_raddr),
        .rdata_o (lb0_rdata)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (LB_AW)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (lb_waddr),
        .wdata_i (bus.pix_in),
        .raddr_i (lb_raddr),
        .rdata_o (lb1_rdata)
    );

    // sw_*[c][r]: column c (0 = oldest), row r (0 = top row y-2).
    always_comb begin
        for (int unsigned c = 0; c < WIN_DIM; c++) begin
            for (int unsigned r = 0; r < WIN_DIM; r++) begin
                sw_d[c][r] = sw_q[c][r];
            end
        end
        if (accept) begin
            for (int unsigned c = 0; c < WIN_DIM - 1; c++) begin
                for (int unsigned r = 0; r < WIN_DIM; r++) begin
                    sw_d[c][r] = sw_q[c+1][r];
                end
            end
            sw_d[WIN_DIM-1][0] = lb0_rdata;
            sw_d[WIN_DIM-1][1] = lb1_rdata;
            sw_d[WIN_DIM-1][2] = bus.pix_in;
        end
    end

    always_comb begin
        win_data_d = win_data_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        if (emit) begin
            for (int unsigned r = 0; r < WIN_DIM; r++) begin
                for (int unsigned c = 0; c < WIN_DIM; c++) begin
                    win_data_d[win_off(r, c, 0) +: PIX_W] = sw_d[c][r];
                end
            end
            win_row_d = y_q - IDX_TWO;
            win_col_d = x_q - IDX_TWO;
        end

        if (emit) begin
            win_valid_d = 1'b1;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end

        frame_done_d = accept && last_col && last_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            sw_q         <= '{default: '0};
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            sw_q         <= sw_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_data   = win_data_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x5 image.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int unsigned W = 5;
    localparam int unsigned H = 5;
    localparam int unsigned NO_STALL = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_gen_if bus ();

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    function automatic pix_t pix(input int unsigned y, input int unsigned x);
        logic [7:0] b;
        b = 8'(y * 16 + x);
        return {b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic win_t exp_win(input int unsigned wr, input int unsigned wc);
        win_t w;
        w = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w[(r * 3 + c) * 24 +: 24] = pix(wr + r, wc + c);
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input win_t obs, input win_t exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pix_ready"}, win_t'(bus.pix_ready), win_t'(1));
        chk({tag, "_win_valid"}, win_t'(bus.win_valid), '0);
        chk({tag, "_win_data"}, bus.win_data, '0);
        chk({tag, "_win_row"}, win_t'(bus.win_row), '0);
        chk({tag, "_win_col"}, win_t'(bus.win_col), '0);
        chk({tag, "_frame_done"}, win_t'(bus.frame_done), '0);
    endtask

    // Streams npix pixels in raster order from (0,0), holding win_ready low for
    // stall_len cycles while window number stall_idx is presented.
    task automatic stream(input int unsigned npix, input int unsigned stall_idx,
                          input int unsigned stall_len, input bit drain,
                          output int unsigned nwin);
        int unsigned y = 0, x = 0, acc = 0, held = 0, cyc = 0;
        int unsigned er = 0, ec = 0;
        logic ev = 1'b0;
        logic rdy, ld, last, stalling;
        win_t d;
        nwin = 0;
        while (acc < npix && cyc < 400) begin
            stalling      = ev && (nwin == stall_idx) && (held < stall_len);
            bus.pix_in    = pix(y, x);
            bus.pix_valid = 1'b1;
            bus.win_ready = !stalling;
            #1;
            rdy = bus.pix_ready;
            chk(stalling ? "pix_ready_hold" : "pix_ready", win_t'(rdy), win_t'(!stalling));
            @(posedge clk);
            #1;
            cyc++;
            if (ev && !stalling) nwin++;
            if (stalling) held++;
            ld   = 1'b0;
            last = 1'b0;
            if (rdy) begin
                acc++;
                last = (y == H - 1) && (x == W - 1);
                if (y >= 2 && x >= 2) begin
                    ld = 1'b1;
                    er = y - 2;
                    ec = x - 2;
                end
                if (x == W - 1) begin
                    x = 0;
                    y = (y == H - 1) ? 0 : y + 1;
                end else begin
                    x++;
                end
            end
            ev = ld ? 1'b1 : (stalling ? ev : 1'b0);
            d  = bus.win_data;
            chk("win_valid", win_t'(bus.win_valid), win_t'(ev));
            chk("frame_done", win_t'(bus.frame_done), win_t'(last));
            if (ev) begin
                chk(ld ? "win_data" : "win_data_held", d, exp_win(er, ec));
                chk("win_row", win_t'(bus.win_row), win_t'(er));
                chk("win_col", win_t'(bus.win_col), win_t'(ec));
            end
            if (ld && er == 0 && ec == 0) begin
                chk("w00_e00_ch0", win_t'(d[7:0]), win_t'(8'h00));
                chk("w00_e22_ch0", win_t'(d[192 +: 8]), win_t'(8'h22));
            end
            if (ld && er == 2 && ec == 2) chk("w22_e22_ch0", win_t'(d[192 +: 8]), win_t'(8'h44));
            if (ld && er == 1 && ec == 0) chk("w10_e00_ch0", win_t'(d[7:0]), win_t'(8'h10));
        end
        chk("stream_accepts", win_t'(acc), win_t'(npix));
        chk("stream_no_stall_cycles", win_t'(cyc), win_t'(npix + ((stall_len <= 400) ? stall_len : 0)));
        bus.pix_valid = 1'b0;
        if (drain) begin
            bus.win_ready = 1'b1;
            @(posedge clk);
            #1;
            if (ev) nwin++;
            chk("drain_win_valid", win_t'(bus.win_valid), '0);
            chk("drain_frame_done", win_t'(bus.frame_done), '0);
        end
    endtask

    initial begin
        int unsigned nwin;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        stream(25, NO_STALL, 0, 1'b1, nwin);
        chk("frame_windows", win_t'(nwin), win_t'(9));

        stream(25, 0, 7, 1'b1, nwin);
        chk("stall_windows", win_t'(nwin), win_t'(9));

        stream(50, NO_STALL, 0, 1'b1, nwin);
        chk("b2b_windows", win_t'(nwin), win_t'(18));

        stream(13, NO_STALL, 0, 1'b0, nwin);
        chk("pre_reset_valid", win_t'(bus.win_valid), win_t'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(25, NO_STALL, 0, 1'b1, nwin);
        chk("after_reset_windows", win_t'(nwin), win_t'(9));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
